conv1d_out_requant: RTL and testbench

- Downstream stage of the conv1d CFU engine.
- Consumes raw signed 32-bit conv1d accumulators one per handshake and requantizes each to int8 (bias, Q31 multiply, rounding shift, output offset, clamp).
- Packs four int8 results into one 32-bit word and holds packed words in a FIFO.
- The CFU read command pops the FIFO.

---
 rtl/conv1d_out_requant.sv | 173 +++++++++++++++++
 tb/tb_conv1d_out_requant.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv1d_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : conv1d_out_requant
// Brief    : Requantizes conv1d int32 accumulators to int8, packs four per
//            32-bit word and buffers the words in a first-word-fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module conv1d_out_requant #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   acc_valid,
    output logic                   acc_ready,
    input  logic [31:0]            acc_data,
    input  logic [31:0]            cfg_bias,
    input  logic [31:0]            cfg_mult,
    input  logic [3:0]             cfg_shift,
    input  logic [7:0]             cfg_offset,
    input  logic [7:0]             cfg_act_min,
    input  logic [7:0]             cfg_act_max,
    input  logic                   flush,
    input  logic                   rd_pop,
    output logic                   rd_valid,
    output logic [31:0]            rd_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   overflow
);
    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_ready_max = (c_aw + 1)'(DEPTH - 2);
    localparam logic [c_aw:0]   c_full      = (c_aw + 1)'(DEPTH);
    localparam logic [c_aw:0]   c_cnt_one   = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0] c_ptr_one   = c_aw'(1);

    logic               r_v1, r_v2, r_v3;
    logic signed [31:0] r_sum;
    logic signed [63:0] r_prod;
    logic [7:0]         r_byte;
    logic [1:0]         r_lane;
    logic [23:0]        r_part;
    logic               r_flush_pend;
    logic [31:0]        r_mem [DEPTH];
    logic [c_aw-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]      r_count;
    logic [31:0]        r_last;
    logic               r_overflow;

    logic               w_accept, w_pipe_empty, w_flush_go;
    logic               w_push_full, w_push_part, w_push, w_pop, w_full, w_wr_en;
    logic [31:0]        w_push_word;
    logic signed [63:0] w_prod;
    logic [5:0]         w_sh;
    logic signed [64:0] w_rsum, w_shr, w_val, w_min, w_max;
    logic [7:0]         w_byte;

    // Ready leaves room for every sample that can still be in flight.
    assign acc_ready = !reset && !r_flush_pend && (r_count <= c_ready_max);
    assign w_accept  = acc_valid && acc_ready;

    assign w_prod = $signed({{32{r_sum[31]}}, r_sum}) * $signed({{32{cfg_mult[31]}}, cfg_mult});

    // Output stage in 65-bit signed arithmetic; results always fit in 34 bits.
    always_comb begin
        w_sh   = 6'd31 + {2'b00, cfg_shift};
        w_rsum = {r_prod[63], r_prod} + (65'd1 << (w_sh - 6'd1));
        w_shr  = w_rsum >>> w_sh;
        w_val  = w_shr + {{57{cfg_offset[7]}}, cfg_offset};
        w_min  = {{57{cfg_act_min[7]}}, cfg_act_min};
        w_max  = {{57{cfg_act_max[7]}}, cfg_act_max};
        w_byte = w_val[7:0];
        if (w_val > w_max) begin
            w_byte = cfg_act_max;
        end else if (w_val < w_min) begin
            w_byte = cfg_act_min;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_sum  <= '0;
            r_prod <= '0;
            r_byte <= '0;
        end else begin
            r_v1   <= w_accept;
            r_v2   <= r_v1;
            r_v3   <= r_v2;
            r_sum  <= acc_data + cfg_bias;
            r_prod <= w_prod;
            r_byte <= w_byte;
        end
    end

    assign w_pipe_empty = !(r_v1 || r_v2 || r_v3);
    assign w_flush_go   = r_flush_pend && w_pipe_empty;
    assign w_push_full  = r_v3 && (r_lane == 2'd3);
    assign w_push_part  = w_flush_go && (r_lane != 2'd0);
    assign w_push       = w_push_full || w_push_part;
    assign w_push_word  = w_push_full ? {r_byte, r_part} : {8'h00, r_part};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane       <= 2'd0;
            r_part       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (r_v3) begin
                r_lane <= r_lane + 2'd1;
                case (r_lane)
                    2'd0:    r_part[7:0]   <= r_byte;
                    2'd1:    r_part[15:8]  <= r_byte;
                    2'd2:    r_part[23:16] <= r_byte;
                    default: r_part        <= '0;
                endcase
            end else if (w_flush_go) begin
                r_lane <= 2'd0;
                r_part <= '0;
            end
            // A new pulse wins over the clear of an older pending flush.
            if (flush) begin
                r_flush_pend <= 1'b1;
            end else if (w_flush_go) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

    assign w_pop   = rd_pop && (r_count != '0);
    assign w_full  = (r_count == c_full);
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // When empty, the last popped word stays on the read port.
    assign rd_valid   = (r_count != '0);
    assign rd_data    = rd_valid ? r_mem[r_rd_ptr] : r_last;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_conv1d_out_requant.sv
`default_nettype none
// Bench for conv1d_out_requant: queue-based reference model checked every
// cycle, plus directed words with hand-computed values.
module tb_conv1d_out_requant;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, acc_valid, flush, rd_pop;
    logic [31:0] acc_data, cfg_bias, cfg_mult;
    logic [3:0]  cfg_shift;
    logic [7:0]  cfg_offset, cfg_act_min, cfg_act_max;
    logic        acc_ready, rd_valid, overflow;
    logic [31:0] rd_data;
    logic [$clog2(DEPTH):0] fifo_count;

    conv1d_out_requant #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_data(acc_data), .cfg_bias(cfg_bias), .cfg_mult(cfg_mult),
        .cfg_shift(cfg_shift), .cfg_offset(cfg_offset), .cfg_act_min(cfg_act_min),
        .cfg_act_max(cfg_act_max), .flush(flush), .rd_pop(rd_pop),
        .rd_valid(rd_valid), .rd_data(rd_data), .fifo_count(fifo_count),
        .overflow(overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [7:0] b; int due; } flight_t;
    flight_t     flight_q[$];
    logic [7:0]  lanes_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] m_last = '0;
    bit          m_pend = 1'b0;
    bit          m_ovf  = 1'b0;
    int          cyc    = 0;

    function automatic logic [7:0] requant(input logic [31:0] a);
        int     s, sh;
        longint p, r, v;
        s  = int'(a) + int'(cfg_bias);
        p  = longint'(s) * longint'(int'(cfg_mult));
        sh = 31 + int'(cfg_shift);
        r  = (p + (longint'(1) <<< (sh - 1))) >>> sh;
        v  = r + longint'(byte'(cfg_offset));
        if (v > longint'(byte'(cfg_act_max)))      v = longint'(byte'(cfg_act_max));
        else if (v < longint'(byte'(cfg_act_min))) v = longint'(byte'(cfg_act_min));
        return v[7:0];
    endfunction

    function automatic bit m_ready();
        return !reset && !m_pend && (fifo_q.size() <= DEPTH - 2);
    endfunction

    always @(posedge clk) begin
        bit          rdy, do_push;
        logic [31:0] w;
        flight_t     f;
        rdy     = m_ready();
        do_push = 1'b0;
        w       = '0;
        if (reset) begin
            flight_q.delete(); lanes_q.delete(); fifo_q.delete();
            m_last = '0; m_pend = 1'b0; m_ovf = 1'b0;
        end else begin
            if (rd_pop && fifo_q.size() > 0) m_last = fifo_q.pop_front();
            if (flight_q.size() > 0 && flight_q[0].due == cyc) begin
                f = flight_q.pop_front();
                lanes_q.push_back(f.b);
                if (lanes_q.size() == 4) begin
                    w = {lanes_q[3], lanes_q[2], lanes_q[1], lanes_q[0]};
                    lanes_q.delete();
                    do_push = 1'b1;
                end
            end else if (m_pend && flight_q.size() == 0) begin
                if (lanes_q.size() > 0) begin
                    for (int i = 0; i < lanes_q.size(); i++) w[8*i +: 8] = lanes_q[i];
                    lanes_q.delete();
                    do_push = 1'b1;
                end
                m_pend = 1'b0;
            end
            if (do_push) begin
                if (fifo_q.size() < DEPTH) fifo_q.push_back(w);
                else m_ovf = 1'b1;
            end
            if (flush) m_pend = 1'b1;
            if (acc_valid && rdy) begin
                f.b   = requant(acc_data);
                f.due = cyc + 3;
                flight_q.push_back(f);
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        chk("acc_ready",  acc_ready,  m_ready());
        chk("rd_valid",   rd_valid,   fifo_q.size() > 0);
        chk("rd_data",    rd_data,    fifo_q.size() > 0 ? fifo_q[0] : m_last);
        chk("fifo_count", fifo_count, fifo_q.size());
        chk("overflow",   overflow,   m_ovf);
    end

    // ---------------- stimulus ----------------
    int          pop_mode = 0;
    logic [31:0] popped_q[$];

    task automatic tick();
        if (rd_pop && rd_valid) popped_q.push_back(rd_data);
        @(posedge clk);
        #1;
        case (pop_mode)
            0:       rd_pop = 1'b0;
            1:       rd_pop = 1'b1;
            default: rd_pop = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send(input logic [31:0] d, input bit fl);
        bit acc;
        int n;
        acc_valid = 1'b1; acc_data = d; flush = fl; n = 0;
        do begin
            acc = acc_ready;
            tick();
            flush = 1'b0;
            n++;
        end while (!acc && n < 200);
        acc_valid = 1'b0;
        chk("accept_in_time", acc, 1'b1);
    endtask

    task automatic wait_word();
        int n = 0;
        while (!rd_valid && n < 20) begin tick(); n++; end
        chk("word_in_time", rd_valid, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (8) tick();
        pop_mode = 1; rd_pop = 1'b1;
        while (rd_valid && n < 50) begin tick(); n++; end
        pop_mode = 0; rd_pop = 1'b0;
        tick();
        chk("drained", rd_valid, 1'b0);
    endtask

    task automatic set_cfg(input logic [31:0] b, input logic [31:0] m, input logic [3:0] s,
                           input logic [7:0] o, input logic [7:0] lo, input logic [7:0] hi);
        cfg_bias = b; cfg_mult = m; cfg_shift = s;
        cfg_offset = o; cfg_act_min = lo; cfg_act_max = hi;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nacc, stall, n;
        logic [31:0] e;
        byte         a, b;
        reset = 1'b1; acc_valid = 1'b0; flush = 1'b0; rd_pop = 1'b0; acc_data = '0;
        set_cfg(32'd0, 32'h4000_0000, 4'd0, 8'h80, 8'h80, 8'h7F);
        tick(); tick();
        chk("ready_in_reset", acc_ready, 1'b0);
        reset = 1'b0;
        tick();
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_count", fifo_count, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("ready_after_reset", acc_ready, 1'b1);

        // Single word with offset -128, and its latency
        send(32'd10, 0); send(32'd20, 0); send(32'd30, 0); send(32'd40, 0);
        tick(); tick();
        chk("lat_not_yet", rd_valid, 1'b0);
        tick();
        chk("lat_valid", rd_valid, 1'b1);
        chk("word_single", rd_data, 32'h948F_8A85);
        chk("count_single", fifo_count, 1);
        drain();

        // Rounding half up and clamping
        set_cfg(32'd0, 32'h4000_0000, 4'd0, 8'h00, 8'h80, 8'h7F);
        send(32'd100, 0); send(-32'sd3, 0); send(32'd1000, 0); send(-32'sd1000, 0);
        wait_word();
        chk("word_round_clamp", rd_data, 32'h807F_FF32);
        drain();

        // Bias and extra shift
        set_cfg(32'd6, 32'h4000_0000, 4'd2, 8'h00, 8'h80, 8'h7F);
        repeat (4) send(32'd10, 0);
        wait_word();
        chk("word_shift_bias", rd_data, 32'h0202_0202);
        drain();

        // Partial word on flush, then a flush with nothing to push
        set_cfg(32'd0, 32'h4000_0000, 4'd0, 8'h00, 8'h80, 8'h7F);
        send(32'd2, 0); send(32'd4, 0);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_word();
        chk("word_flush", rd_data, 32'h0000_0201);
        drain();
        flush = 1'b1; tick(); flush = 1'b0;
        repeat (6) tick();
        chk("empty_flush_count", fifo_count, 0);
        chk("empty_flush_ready", acc_ready, 1'b1);

        // Backpressure with no pops, then pop everything
        popped_q.delete(); nacc = 0; stall = 0;
        acc_valid = 1'b1;
        while (nacc < 24 && stall < 8) begin
            acc_data = 32'(2 * nacc);
            if (acc_ready) begin tick(); nacc++; stall = 0; end
            else begin tick(); stall++; end
        end
        acc_valid = 1'b0;
        chk("bp_accepted", nacc, 15);
        chk("bp_count", fifo_count, 3);
        chk("bp_ready", acc_ready, 1'b0);
        chk("bp_overflow", overflow, 1'b0);
        pop_mode = 1; rd_pop = 1'b1;
        for (int i = nacc; i < 24; i++) send(32'(2 * i), 0);
        n = 0;
        while (popped_q.size() < 6 && n < 100) begin tick(); n++; end
        pop_mode = 0; rd_pop = 1'b0;
        tick();
        chk("bp_words", popped_q.size(), 6);
        for (int k = 0; k < popped_q.size() && k < 6; k++) begin
            e = {8'(4*k + 3), 8'(4*k + 2), 8'(4*k + 1), 8'(4*k)};
            chk("bp_word_order", popped_q[k], e);
        end
        chk("bp_overflow_end", overflow, 1'b0);

        // Reset in the middle of a stream
        for (int i = 0; i < 6; i++) send(32'(2 * i), 0);
        wait_word();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_valid", rd_valid, 1'b0);
        chk("midrst_count", fifo_count, 0);
        tick();
        for (int i = 10; i < 14; i++) send(32'(2 * i), 0);
        wait_word();
        chk("midrst_word", rd_data, 32'h0D0C_0B0A);
        drain();

        // Randomized rounds, config changed only while idle
        for (int r = 0; r < 8; r++) begin
            a = byte'($urandom); b = byte'($urandom);
            if (a > b) begin byte t; t = a; a = b; b = t; end
            set_cfg((r % 2 == 0) ? 32'($urandom_range(0, 2000)) - 32'd1000 : $urandom,
                    $urandom, 4'($urandom_range(0, 15)), 8'($urandom), a, b);
            pop_mode = 2;
            for (int k = 0; k < 40; k++) begin
                if ($urandom_range(0, 3) == 0) tick();
                send((r % 2 == 0) ? 32'($urandom_range(0, 6000)) - 32'd3000 : $urandom,
                     $urandom_range(0, 19) == 0);
            end
            pop_mode = 0;
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
